keypad_input: RTL

- Input-side counterpart to the display output port.
- Scans a 4x4 active-low key matrix, debounces presses and buffers key codes.
- Presents the oldest key to the CPU bus when the input-port read enable is asserted.
- Runs entirely on `sys_clk`; the CPU reads it via a control-word strobe, in the same way the display is written.

---
 rtl/keypad_input.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low key matrix, debounces one key per
// frame and buffers key codes for the CPU input port.
// Build option KEYPAD_FIFO_EN: 4-entry key FIFO instead of a single
// holding register.
module keypad_input #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       read_en,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  output logic       key_valid
);

  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned CNT_W1 = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_RELEASE
  } state_t;

  // scanner / frame accumulation
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_rows;
  logic [1:0]       r_hits;     // low bits seen this frame, saturating at 2
  logic [3:0]       r_code;
  logic             w_sample;
  logic             w_frame_end;
  logic [3:0]       w_col_low;
  logic [2:0]       w_row_hits;
  logic [1:0]       w_row_col;
  logic [2:0]       w_hit_sum;
  logic [1:0]       w_acc_hits;
  logic [3:0]       w_acc_code;
  logic             w_res_key;

  // debounce
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
  logic [CNT_W1-1:0] w_cnt_inc;
  logic             w_cnt_done;
  logic             w_push;
  logic [3:0]       w_push_code;

  // buffer / bus
  logic             r_read_en_q;
  logic             r_ovr;
  logic             r_key_valid;
  logic             w_fall;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic             w_full;
  logic             w_nonempty;
  logic [3:0]       w_head;

  assign w_sample    = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_sample && (r_row_idx == 2'd3);

  // Row slot timing and per-frame accumulation of low column bits
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_row_idx <= 2'd0;
      r_rows    <= 4'b1110;
      r_hits    <= 2'd0;
      r_code    <= 4'h0;
    end else if (w_sample) begin
      r_div_cnt <= '0;
      r_row_idx <= r_row_idx + 2'd1;
      r_rows    <= {r_rows[2:0], r_rows[3]};
      if (w_frame_end) begin
        r_hits <= 2'd0;
        r_code <= 4'h0;
      end else begin
        r_hits <= w_acc_hits;
        r_code <= w_acc_code;
      end
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Count low columns in the current row and merge with the frame so far
  always_comb begin
    w_col_low  = ~cols;
    w_row_hits = 3'd0;
    w_row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (w_col_low[c]) begin
        w_row_hits = w_row_hits + 3'd1;
        w_row_col  = 2'(c);
      end
    end
    w_hit_sum  = 3'(r_hits) + w_row_hits;
    w_acc_hits = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
    w_acc_code = ((r_hits == 2'd0) && (w_row_hits == 3'd1)) ? {r_row_idx, w_row_col} : r_code;
    w_res_key  = (w_acc_hits == 2'd1);
  end

  // Debounce state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= 4'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Debounce next state, evaluated once per frame end
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_code = r_cand;
    w_cnt_inc   = CNT_W1'(r_cnt) + CNT_W1'(1);
    w_cnt_done  = (w_cnt_inc >= CNT_W1'(DEBOUNCE_SCANS));
    w_cnt_sat   = w_cnt_done ? CNT_W'(DEBOUNCE_SCANS) : w_cnt_inc[CNT_W-1:0];
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_res_key) begin
            w_cand_nxt = w_acc_code;
            w_cnt_nxt  = CNT_W'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              w_push      = 1'b1;
              w_push_code = w_acc_code;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (!w_res_key) begin
            w_state_nxt = S_IDLE;
          end else if (w_acc_code == r_cand) begin
            w_cnt_nxt = w_cnt_sat;
            if (w_cnt_done) begin
              w_push      = 1'b1;
              w_state_nxt = S_HELD;
            end
          end else begin
            w_cand_nxt = w_acc_code;
            w_cnt_nxt  = CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_res_key) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (DEBOUNCE_SCANS <= 1) ? S_IDLE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!w_res_key) begin
            w_cnt_nxt = w_cnt_sat;
            if (w_cnt_done) w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Consume happens on the read_en falling edge; a pop frees room for a push
  assign w_fall   = r_read_en_q && !read_en;
  assign w_pop    = w_fall && w_nonempty;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && !w_accept;

`ifdef KEYPAD_FIFO_EN
  logic [3:0] r_fifo [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [2:0] w_count_nxt;

  assign w_full      = (r_count == 3'd4);
  assign w_nonempty  = (r_count != 3'd0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_count_nxt = r_count + 3'(w_accept) - 3'(w_pop);

  // Key FIFO storage and pointers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 4'h0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_key_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_push_code;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count     <= w_count_nxt;
      r_key_valid <= (w_count_nxt != 3'd0);
    end
  end
`else
  logic [3:0] r_hold_code;

  assign w_full     = r_key_valid;
  assign w_nonempty = r_key_valid;
  assign w_head     = r_hold_code;

  // Single holding register; a simultaneous pop and push loads the new code
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_hold_code <= 4'h0;
      r_key_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_code <= w_push_code;
      r_key_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_code <= 4'h0;
      r_key_valid <= 1'b0;
    end
  end
`endif

  // Read-edge history and sticky overrun flag
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_read_en_q <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_read_en_q <= read_en;
      if (w_drop) r_ovr <= 1'b1;
      else if (w_fall) r_ovr <= 1'b0;
    end
  end

  // Zero-latency bus view of the buffer head
  always_comb begin
    bus_out = 8'h00;
    if (read_en) bus_out = {r_key_valid, r_ovr, 2'b00, (w_nonempty ? w_head : 4'h0)};
  end

  assign bus_drive = read_en;
  assign key_valid = r_key_valid;
  assign rows      = r_rows;

endmodule
